wb_stage: RTL
=============

Name: wb_stage

Overview:
Writeback stage of the 5-stage pipeline, directly upstream of the register file write port and its WB forwarding input. It registers the MEM-stage bus and extracts, aligns and sign- or zero-extends load data from the synchronous data SRAM. It drives the regfile write port, the 38-bit WB forwarding bus and the debug trace outputs. It holds on WB stall, inserts bubbles and flushes.

Parameters:
RESET_PC, 32'h0000_0000, value of debug_wb_pc while reset or bubble

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
stall_mem  in  1  MEM stage stalled this cycle
stall_wb  in  1  WB stage stalled; hold register contents
flush  in  1  discard the instruction entering WB
mem_valid  in  1  mem_to_wb_bus carries a live instruction
mem_to_wb_bus  in  75  {pc[74:43], rf_we[42], rf_waddr[41:37], result[36:5], ld_op[4:2], addr_lo[1:0]}
data_sram_rdata  in  32  SRAM read data; valid in the first cycle a load occupies WB
rf_we  out  1  regfile write enable
rf_waddr  out  5  regfile write address
rf_wdata  out  32  regfile write data
wb_to_id_bus  out  38  {rf_we, rf_waddr, rf_wdata}, forwarding to ID
ld_misalign  out  1  current load is misaligned; write suppressed
debug_wb_pc  out  32  PC of instruction in WB
debug_wb_rf_wen  out  4  {4{rf_we}}
debug_wb_rf_wnum  out  5  = rf_waddr
debug_wb_rf_wdata  out  32  = rf_wdata

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous, active-high. Reset clears the valid bit, the stored bus fields, the first-cycle flag and the hold register. During reset rf_we=0, rf_waddr=0, rf_wdata=0, ld_misalign=0, debug_wb_pc=RESET_PC.
- Register update at posedge clk, in priority order:
  - flush: valid<=0.
  - stall_wb: hold all fields.
  - stall_mem: bubble, valid<=0.
  - otherwise: load the bus, valid<=mem_valid.
- first flag: set to 1 on a cycle that loads a valid instruction. Cleared on every other cycle.
- hold register: captures data_sram_rdata when first=1 and stall_wb=1.
- Load data source: ld_data = first ? data_sram_rdata : hold register. Stalled loads therefore keep correct data after the SRAM output changes.
- ld_op encoding:
  - 000: none, wdata = result.
  - 001 lb / 010 lbu: byte addr_lo, little-endian, sign- or zero-extended.
  - 011 lh / 100 lhu: halfword addr_lo[1].
  - 101 lw: full word.
  - 110/111: treated as none.
- Misalignment: lh/lhu with addr_lo[0]=1, or lw with addr_lo!=0 -> ld_misalign=valid; rf_we forced to 0.
- Combinational outputs:
  - rf_we = valid & stored rf_we & ~ld_misalign.
  - rf_waddr and rf_wdata are 0 when valid=0.
- rf_we stays asserted on every held cycle, with identical data. The repeated regfile write is idempotent, and forwarding stays correct.
- Latency: a bus value accepted at edge N appears on the outputs after edge N. The regfile commits at edge N+1.
- debug_wb_pc = valid ? stored pc : RESET_PC.
- Reset mid-stall: all state clears immediately; the first cycle after release is a bubble.
- Simultaneous flush and stall_wb: flush wins.

Optional Feature:
WB_RETIRE_CNT_EN:
- Defined: adds output retire_cnt [31:0].
  - Increments once per valid instruction leaving WB, counted on cycles where valid=1 and stall_wb=0, misaligned loads included.
  - Wraps 32'hFFFF_FFFF -> 0.
  - Cleared by rst.
- Undefined: no port and no counter logic.

Test Plan:
- ALU op: bus with pc=0xBFC00000, rf_we=1, waddr=5, result=0x12345678, ld_op=0 -> next cycle rf_we=1, waddr=5, wdata=0x12345678, debug_wb_rf_wen=4'hF.
- lb sign-extension: addr_lo=2, rdata=0x00800000 -> wdata=0xFFFFFF80. Same input with lbu -> wdata=0x00000080.
- Stalled lw: lw, rdata=0xCAFEF00D, then stall_wb=1 for 3 cycles with rdata changed to 0xDEADBEEF -> wdata stays 0xCAFEF00D every cycle.
- Misaligned lw: lw with addr_lo=1 -> ld_misalign=1, rf_we=0. A following aligned lh with addr_lo=2 and rdata=0x7FFF0000 -> wdata=0x00007FFF.
- Flush, bubble and reset:
  - flush together with stall_wb -> rf_we=0, debug_wb_pc=RESET_PC next cycle.
  - stall_mem=1, stall_wb=0 -> bubble.
  - rst asserted mid-cycle -> outputs clear without waiting for a clk edge.
- WB_RETIRE_CNT_EN: 4 valid instructions plus 2 stall cycles -> retire_cnt=4. Preload near 32'hFFFF_FFFF -> wraps to 0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: registers the MEM-stage bus, aligns/extends SRAM load data and drives the
// regfile write port, WB forwarding bus and debug trace. Optional macro: WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_mem,
  input  logic        stall_wb,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic [74:0] mem_to_wb_bus,
  input  logic [31:0] data_sram_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [37:0] wb_to_id_bus,
  output logic        ld_misalign,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0] debug_wb_rf_wdata,
  output logic [31:0] retire_cnt
`else
  output logic [31:0] debug_wb_rf_wdata
`endif
);

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
    logic [2:0]  ld_op;
    logic [1:0]  addr_lo;
  } wb_bus_t;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_B    = 3'b001,
    LD_BU   = 3'b010,
    LD_H    = 3'b011,
    LD_HU   = 3'b100,
    LD_W    = 3'b101
  } ld_op_e;

  wb_bus_t     bus_q;
  logic        valid_q;
  logic        first_q;
  logic [31:0] hold_q;

  // The SRAM only presents load data in the first WB cycle, so a stalled load
  // must keep its own copy for the remaining held cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      bus_q   <= '0;
      first_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
      if (first_q && stall_wb) hold_q <= data_sram_rdata;
      first_q <= 1'b0;
      if (flush) begin
        valid_q <= 1'b0;
      end else if (stall_wb) begin
        valid_q <= valid_q;
      end else if (stall_mem) begin
        valid_q <= 1'b0;
      end else begin
        bus_q   <= wb_bus_t'(mem_to_wb_bus);
        valid_q <= mem_valid;
        first_q <= mem_valid;
      end
    end
  end

  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] wdata_sel;
  logic        misalign;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one unassigned (no latch).
    ld_data   = first_q ? data_sram_rdata : hold_q;
    ld_byte   = ld_data[7:0];
    ld_half   = bus_q.addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
    wdata_sel = bus_q.result;
    misalign  = 1'b0;

    case (bus_q.addr_lo)
      2'd1:    ld_byte = ld_data[15:8];
      2'd2:    ld_byte = ld_data[23:16];
      2'd3:    ld_byte = ld_data[31:24];
      default: ld_byte = ld_data[7:0];
    endcase

    case (bus_q.ld_op)
      LD_B:  wdata_sel = {{24{ld_byte[7]}}, ld_byte};
      LD_BU: wdata_sel = {24'h0, ld_byte};
      LD_H: begin
        wdata_sel = {{16{ld_half[15]}}, ld_half};
        misalign  = bus_q.addr_lo[0];
      end
      LD_HU: begin
        wdata_sel = {16'h0, ld_half};
        misalign  = bus_q.addr_lo[0];
      end
      LD_W: begin
        wdata_sel = ld_data;
        misalign  = (bus_q.addr_lo != 2'd0);
      end
      default: wdata_sel = bus_q.result;
    endcase
  end

  // A held instruction keeps rf_we asserted; rewriting the same value is harmless.
  assign ld_misalign = valid_q & misalign;
  assign rf_we       = valid_q & bus_q.rf_we & ~misalign;
  assign rf_waddr    = valid_q ? bus_q.rf_waddr : 5'd0;
  assign rf_wdata    = valid_q ? wdata_sel : 32'd0;

  assign wb_to_id_bus      = {rf_we, rf_waddr, rf_wdata};
  assign debug_wb_pc       = valid_q ? bus_q.pc : RESET_PC;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

`ifdef WB_RETIRE_CNT_EN
  // Counts instructions leaving WB, misaligned loads included; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (valid_q && !stall_wb) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule
